// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared types and constants for the parity_arb codebase slice.
//   state_t    : result-register FSM state (EMPTY / FULL)
//   DEF_NUM_REQ: default number of requesters
//   DEF_DATA_W : default word width
//   ERR_CNT_W  : width of the saturating parity-mismatch counter
// ---------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic {
    EMPTY = 1'b0,  // result register holds nothing
    FULL  = 1'b1   // result register holds a valid result
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int ERR_CNT_W   = 8;

endpackage : parity_pkg

// File: rtl/parity_arb_if.sv
// ---------------------------------------------------------------------------
// parity_arb_if
// Bundles the requester handshake and the result port of parity_arb.
//   req_valid  [NUM_REQ]        requester i offers a word
//   req_data   [NUM_REQ*DATA_W] word of requester i at [i*DATA_W +: DATA_W]
//   req_ready  [NUM_REQ]        one-hot/zero accept strobe
//   res_valid, res_ready        result handshake
//   res_id     [ID_W]           index of the requester that produced the result
//   res_parity                  XOR of all bits of the accepted word
// Optional (macro PARITY_CHECK_EN):
//   req_par [NUM_REQ]           expected parity per requester
//   res_err                     res_parity differs from captured req_par bit
//   err_cnt [ERR_CNT_W]         saturating mismatch counter
// Modports: master = requesters/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface parity_arb_if
  import parity_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic                      res_parity;
`ifdef PARITY_CHECK_EN
  logic [NUM_REQ-1:0]        req_par;
  logic                      res_err;
  logic [ERR_CNT_W-1:0]      err_cnt;
`endif

  modport master (
    output req_valid, req_data, res_ready,
`ifdef PARITY_CHECK_EN
    output req_par,
    input  res_err, err_cnt,
`endif
    input  req_ready, res_valid, res_id, res_parity
  );

  modport slave (
    input  req_valid, req_data, res_ready,
`ifdef PARITY_CHECK_EN
    input  req_par,
    output res_err, err_cnt,
`endif
    output req_ready, res_valid, res_id, res_parity
  );

endinterface : parity_arb_if

// File: rtl/parity_calc.sv
// ---------------------------------------------------------------------------
// parity_calc
// Combinational even-parity generator: parity = ^data (1 when the number of
// ones in data is odd).
//   data   in  DATA_W  word to reduce
//   parity out 1       XOR of all bits of data
// ---------------------------------------------------------------------------
module parity_calc #(
  parameter int DATA_W = parity_pkg::DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule : parity_calc

// File: rtl/parity_arb.sv
// ---------------------------------------------------------------------------
// parity_arb
// Round-robin arbiter sharing one parity generator among NUM_REQ requesters.
// At most one word is granted per cycle; its parity and the winner's index are
// captured into a registered valid/ready result port (latency 1, full
// throughput while res_ready stays high).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  parity_arb_if.slave (requester handshake + result port)
// Optional feature macro: PARITY_CHECK_EN adds req_par/res_err/err_cnt.
// ---------------------------------------------------------------------------
module parity_arb
  import parity_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  parity_arb_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic            res_valid_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_par_q;

  logic            can_accept;
  logic            any_valid;
  logic            grant;
  logic [ID_W-1:0] win;
  logic [DATA_W-1:0] win_data;
  logic            win_par;
  logic [NUM_REQ-1:0] req_ready_c;

  // Requester index visited at search step k, starting at ptr and wrapping.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] p, input int k);
    return ID_W'((int'(p) + k) % NUM_REQ);
  endfunction

  assign can_accept = (state == EMPTY) || bus.res_ready;

  // First valid requester at or above ptr, with wrap.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && bus.req_valid[rr_index(ptr, k)]) begin
        any_valid = 1'b1;
        win       = rr_index(ptr, k);
      end
    end
  end

  // rst gates the grant so req_ready stays low for the whole reset window.
  assign grant = can_accept && any_valid && !rst;

  always_comb begin
    req_ready_c = '0;
    if (grant) req_ready_c[win] = 1'b1;
  end

  // Data mux feeding the single shared parity unit.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) win_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data   (win_data),
    .parity (win_par)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      ptr         <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_par_q   <= 1'b0;
    end else begin
      if (grant) begin
        res_id_q  <= win;
        res_par_q <= win_par;
        ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
      end
      case (state)
        EMPTY: begin
          if (grant) begin
            state       <= FULL;
            res_valid_q <= 1'b1;
          end
        end
        FULL: begin
          // res_ready low: hold everything; res_ready high with a grant:
          // stay FULL with the new result loaded above.
          if (bus.res_ready && !grant) begin
            state       <= EMPTY;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_parity = res_par_q;

`ifdef PARITY_CHECK_EN
  logic                 chk_par_q;
  logic                 res_err_c;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign res_err_c = res_valid_q && (res_par_q ^ chk_par_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_par_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (grant) chk_par_q <= bus.req_par[win];
      // Count mismatches only when the consumer actually takes the result.
      if (res_valid_q && bus.res_ready && res_err_c && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.res_err = res_err_c;
  assign bus.err_cnt = err_cnt_q;
`endif

endmodule : parity_arb

// File: tb/tb_parity_arb.sv
// ---------------------------------------------------------------------------
// tb_parity_arb
// Directed, self-checking bench for parity_arb (NUM_REQ=4, DATA_W=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Define PARITY_CHECK_EN to also exercise the checker feature.
// ---------------------------------------------------------------------------
module tb_parity_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  parity_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  parity_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] t1_word [4] = '{32'h3456_789a, 32'hc4c6_78ff, 32'hff56_ff9a, 32'h3faa_aaaa};
  logic        t1_par  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  // Words for requesters 0..3: 1 (odd), 3 (even), 7 (odd), 0 (even).
  logic        t2_par  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  // Watchdog: the run is purely clock-driven, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int g;
    int prev;

    rst           = 1'b1;
    bus.req_valid = 4'hf;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
`ifdef PARITY_CHECK_EN
    bus.req_par   = '0;
`endif

    // ---- reset state ----
    @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready),  32'h0);
    check("rst_res_valid",  32'(bus.res_valid),  32'h0);
    check("rst_res_id",     32'(bus.res_id),     32'h0);
    check("rst_res_parity", 32'(bus.res_parity), 32'h0);
`ifdef PARITY_CHECK_EN
    check("rst_res_err",    32'(bus.res_err),    32'h0);
    check("rst_err_cnt",    32'(bus.err_cnt),    32'h0);
`endif
    do_reset();

    // ---- single requester, res_ready=1 ----
    for (int i = 0; i < 4; i++) begin
      bus.req_valid       = 4'b0001;
      bus.req_data[31:0]  = t1_word[i];
      bus.res_ready       = 1'b1;
      @(negedge clk);
      check("t1_req_ready", 32'(bus.req_ready), 32'h1);
      if (i > 0) begin
        check("t1_res_valid",  32'(bus.res_valid),  32'h1);
        check("t1_res_parity", 32'(bus.res_parity), 32'(t1_par[i-1]));
        check("t1_res_id",     32'(bus.res_id),     32'h0);
      end
      step();
    end
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_last_valid",  32'(bus.res_valid),  32'h1);
    check("t1_last_parity", 32'(bus.res_parity), 32'(t1_par[3]));
    step();
    @(negedge clk);
    check("t1_drain_valid", 32'(bus.res_valid), 32'h0);

    // ---- all four requesting, full throughput ----
    do_reset();
    bus.req_data  = {32'h0000_0000, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      @(negedge clk);
      check("t2_req_ready", 32'(bus.req_ready), 32'(1 << g));
      if (k > 0) begin
        check("t2_res_valid",  32'(bus.res_valid),  32'h1);
        check("t2_res_id",     32'(bus.res_id),     32'(prev));
        check("t2_res_parity", 32'(bus.res_parity), 32'(t2_par[prev]));
      end
      prev = g;
      step();
    end
    bus.req_valid = '0;
    @(negedge clk);
    check("t2_last_id", 32'(bus.res_id), 32'h1);

    // ---- backpressure ----
    do_reset();
    bus.req_valid = 4'b0110;
    bus.res_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) grants++;
      if (c == 0) begin
        check("t3_first_grant", 32'(bus.req_ready), 32'h2);
      end else begin
        check("t3_hold_ready", 32'(bus.req_ready), 32'h0);
        check("t3_hold_valid", 32'(bus.res_valid), 32'h1);
        check("t3_hold_id",    32'(bus.res_id),    32'h1);
      end
      step();
      if (c == 0) bus.req_valid = 4'b0100;  // requester 1 saw its ready
    end
    check("t3_grant_count", 32'(grants), 32'h1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t3_release_grant", 32'(bus.req_ready), 32'h4);
    check("t3_release_id",    32'(bus.res_id),    32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t3_next_id",    32'(bus.res_id),    32'h2);
    check("t3_next_valid", 32'(bus.res_valid), 32'h1);
    step();
    @(negedge clk);
    check("t3_drain_valid", 32'(bus.res_valid), 32'h0);

    // ---- reset mid-stream ----
    step();
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t4_full_valid", 32'(bus.res_valid), 32'h1);
    #2;
    rst           = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    check("t4_async_valid", 32'(bus.res_valid), 32'h0);
    check("t4_rst_ready",   32'(bus.req_ready), 32'h0);
    step();
    step();
    rst           = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t4_first_grant", 32'(bus.req_ready), 32'h8);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t4_res_id",    32'(bus.res_id),    32'h3);
    check("t4_res_valid", 32'(bus.res_valid), 32'h1);
    step();

`ifdef PARITY_CHECK_EN
    // ---- parity checker ----
    do_reset();
    bus.req_data[95:64] = 32'h3456_789a;
    bus.req_par         = 4'b0000;
    bus.req_valid       = 4'b0100;
    bus.res_ready       = 1'b1;
    @(negedge clk);
    check("t5_grant", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t5_res_err",     32'(bus.res_err), 32'h1);
    check("t5_cnt_before",  32'(bus.err_cnt), 32'h0);
    step();
    @(negedge clk);
    check("t5_cnt_after",   32'(bus.err_cnt), 32'h1);
    check("t5_err_idle",    32'(bus.res_err), 32'h0);
    step();
    bus.req_valid = 4'b0100;
    for (int r = 0; r < 300; r++) step();
    bus.req_valid = '0;
    step();
    step();
    @(negedge clk);
    check("t5_cnt_sat", 32'(bus.err_cnt), 32'hff);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_parity_arb

// File: doc/parity_arb.md
# parity_arb

Round-robin arbiter and scheduler that shares one even-parity generator among NUM_REQ requesters. Each requester offers a DATA_W-bit word, such as an address, with a valid/ready handshake. The block grants at most one word per cycle to the shared parity unit. It returns the parity bit and the winning requester's index through a registered valid/ready result port. It sits between address-producing agents and any consumer of parity-tagged addresses.

## Interface
- NUM_REQ, default 4: number of requesters; range 2..16.
- DATA_W, default 32: word width.
- ID_W, default $clog2(NUM_REQ): width of res_id; derived, never overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NUM_REQ  bit i set: requester i offers a word.
- req_data  in  NUM_REQ*DATA_W  word of requester i in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot or zero; bit i set: requester i's word is accepted this cycle.
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_id  out  ID_W  index of the requester that produced the result.
- res_parity  out  1  XOR of all bits of the accepted word; 1 when the count of ones is odd.
- req_par  in  NUM_REQ  expected parity per requester. Present only with PARITY_CHECK_EN.
- res_err  out  1  res_parity differs from the captured req_par bit. Present only with PARITY_CHECK_EN.
- err_cnt  out  8  saturating mismatch counter. Present only with PARITY_CHECK_EN.

## Operation
- FSM states:
  - EMPTY: result register invalid.
  - FULL: result register valid.
- can_accept = (state==EMPTY) || res_ready.
- Arbitration:
  - Round-robin pointer ptr, range 0..NUM_REQ-1.
  - The winner is the first i with req_valid[i] set, searching from ptr upward with wrap.
  - A grant happens only when can_accept is true and any req_valid bit is set.
  - On a grant to i: req_ready[i]=1, and ptr becomes i+1, wrapping NUM_REQ-1 to 0.
  - With no grant, ptr holds.
- Capture on a grant: res_id ← i and res_parity ← ^word_i.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY when res_ready is high and there is no grant.
  - FULL→FULL when res_ready is high and there is a grant: back-to-back operation at full throughput.
  - FULL→FULL when res_ready is low: res_id and res_parity hold stable, and all req_ready bits are 0.
- Requester rule: req_valid and req_data stay stable until req_ready is seen. The block never drops an asserted request, and each requester waits at most NUM_REQ-1 grants.
- res_ready while EMPTY is ignored.

## Timing
- req_ready is combinational from req_valid, state, ptr and res_ready.
- No combinational path from req_data to any output.
- Latency: a word accepted in cycle N gives res_valid=1 with its result in cycle N+1.
- Throughput: 1 result per cycle while res_ready is held high.
- Reset values:
  - state=EMPTY, ptr=0.
  - res_valid=0, res_id=0, res_parity=0.
  - req_ready=0 throughout reset.
  - With the macro: res_err=0, err_cnt=0.
- Reset asserted mid-operation discards the held result immediately and asynchronously. The first grant after reset release goes to the lowest valid index.

## Configuration
- PARITY_CHECK_EN, defined:
  - Adds req_par, res_err and err_cnt.
  - On a grant, the block captures req_par[i] alongside the data. res_err = res_parity ^ captured bit, valid only while res_valid is 1.
  - err_cnt increments on each result handshake (res_valid && res_ready) with res_err=1, and saturates at 255.
- PARITY_CHECK_EN, undefined: those ports and their logic are absent. Arbitration and timing are identical in both builds.

## Structure
- Package parity_pkg holds:
  - the state enum typedef (EMPTY, FULL);
  - the default NUM_REQ and DATA_W constants;
  - the err_cnt width constant (8).
- Sub-module parity_calc is the combinational DATA_W-bit XOR reduction with ports data in and parity out. It is instantiated once after the data mux.

## Test plan
- Single requester, res_ready=1. Stimulus on requester 0, one word per cycle: 32'h3456_789a, 32'hc4c6_78ff, 32'hff56_ff9a, 32'h3faa_aaaa. Required res_parity sequence 1,1,0,0, each valid one cycle after its grant, res_id=0.
- All four req_valid held high, res_ready=1. Required grants to 0,1,2,3,0,1 on consecutive cycles; res_id follows one cycle later.
- Backpressure: req_valid=4'b0110 with res_ready=0 for 5 cycles. Required: exactly one grant (requester 1); then res_valid=1, res_id=1 and req_ready=0 all held stable. When res_ready rises, requester 2 is granted in that same cycle.
- Reset mid-stream: assert rst while FULL. Required: res_valid drops to 0 without waiting for a clock edge. After release with req_valid=4'b1000 held high from reset, the first grant goes to requester 3.
- PARITY_CHECK_EN: requester 2 sends 32'h3456_789a with req_par=0. Required: res_err=1, and err_cnt goes 0→1 on the handshake. 300 repeated mismatches leave err_cnt=255.
